hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//   Downstream consumer of the per-instruction register-read timing codes, one code per source operand.
//   Tracks destination registers of instructions in EX/MEM/WB, decides load-use/branch stalls for the
//   instruction in ID, and emits forwarding selects timed to the stage where each operand is consumed.
//   Sits beside the ID stage; drives PC/IF-ID hold, EX bubble insertion, and operand muxes at ID/EX/MEM.
// PARAMETERS
//   CNT_W   16   width of saturating stall-cycle performance counter
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   id_rs        in   5      rs field of ID instruction
//   id_rt        in   5      rt field of ID instruction
//   id_read_rs   in   2      rs read code: 00 none, 01 at EX, 10 at MEM, 11 at ID
//   id_read_rt   in   2      rt read code, same encoding
//   id_wr_en     in   1      ID instruction writes a register
//   id_wr_dst    in   5      destination register of ID instruction
//   id_wr_avail  in   2      stage whose end produces result: 01 EX (ALU/LUI/JAL), 10 MEM (LW)
//   id_flush     in   1      squash ID instruction (enters EX as bubble)
//   stall        out  1      hold PC and IF/ID, insert bubble into EX (combinational)
//   id_fwd_rs    out  2      ID-stage operand select: 00 regfile, 01 EX/MEM reg, 10 MEM/WB reg
//   id_fwd_rt    out  2      same, rt
//   ex_fwd_rs    out  2      EX-stage select for instruction now in EX (registered)
//   ex_fwd_rt    out  2      same, rt
//   mem_fwd_rt   out  2      MEM-stage select for store data of instruction now in MEM (registered)
//   stall_cnt    out  CNT_W  count of cycles with stall=1, saturates at all-ones
// BEHAVIOUR
//   Stage index: ID=1, EX=2, MEM=3, WB=4. Read code -> consumer stage s_c: 11->1, 01->2, 10->3, 00->none.
//   Avail code -> a: 01->2, 10->3. Any other avail code with id_wr_en=1 is treated as 01.
//   Scoreboard slots EX, MEM, WB, each {valid, dst[4:0], a}. dst=0 or wr_en=0 -> slot invalid for matching.
//   Operand match: youngest valid slot (EX before MEM before WB) with dst == operand field, field != 0.
//     Older matches are ignored.
//   Operand with s_c=none, field 0, or no match: no stall, select 00.
//   Stall rule per matched operand at slot stage s_p: stall if s_c + s_p < a + 2. stall = OR over rs, rt.
//     Examples: LW in EX feeding ALU op -> stall; LW in EX feeding SW data -> no stall; ALU in EX feeding
//     BEQ/JR -> stall; LW in MEM feeding BEQ -> stall; anything in WB -> never stall.
//   Select for matched, non-stalling operand: k = s_p + s_c - 1; k=3 -> 01, k=4 -> 10, k>=5 -> 00.
//   id_fwd_* is combinational from current slots; valid only when s_c=ID, else 00.
//   stall and id_fwd_* are combinational (same-cycle) from slots and ID inputs; all else registered.
//   Per clock edge:
//     - MEM <= EX, WB <= MEM always (the unit never freezes downstream stages).
//     - If stall or id_flush: EX <= bubble (valid=0), ex_fwd_* <= 00, pending mem select <= 00.
//     - Otherwise: EX <= {id_wr_en, id_wr_dst, a}.
//       ex_fwd_rs/rt <= computed select if s_c=EX else 00.
//       Pending mem select <= rt select if s_c(rt)=MEM else 00.
//     - mem_fwd_rt <= pending mem select held for instruction in EX (advances with MEM <= EX).
//   Simultaneous stall and id_flush: flush wins for EX contents (bubble either way); stall still asserted,
//     still counted.
//   stall_cnt increments when stall=1, holds at 2^CNT_W-1.
//   Reset (async, any time, incl. mid-stall): all slots invalid, ex_fwd_*, mem_fwd_rt, pending select = 00,
//     stall_cnt = 0. stall and id_fwd_* then follow inputs combinationally (0/00 unless ID inputs imply otherwise;
//     empty slots => no stall).
//   Latency: stall same cycle; EX select 1 cycle after ID acceptance; MEM select 2 cycles.
// TESTING
//   1 LW r2 (avail 10) accepted; next ID ADD r3,r2,r4 (rs at EX) -> stall=1 one cycle, then ex_fwd_rs=10 in EX.
//   2 ADD r5 accepted; next ID BEQ r5,r0 (rs at ID) -> stall=1 one cycle; next cycle id_fwd_rs=01, stall=0.
//   3 LW r6 accepted; next ID SW r6,0(r7) (rt at MEM) -> stall=0; two cycles later mem_fwd_rt=10.
//   4 ADD r1 then ADD r1 then SUB rx,r1 (at EX) -> no stall; ex_fwd_rs=01 (youngest match wins over older).
//   5 Write to r0 in EX, ID reads r0 at ID -> stall=0, id_fwd_rs=00; id_flush during stall -> EX bubble,
//     stall_cnt +1.
//   6 Assert rst during stall with LW in EX -> slots cleared, stall_cnt=0, ex/mem selects 00; preload
//     stall_cnt=all-ones + stall -> holds.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding unit beside the ID stage.
// Tracks EX/MEM/WB destinations, raises load-use/branch stalls and issues per-stage operand selects.
module hazard_fwd_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [1:0]       id_read_rs,
  input  logic [1:0]       id_read_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_dst,
  input  logic [1:0]       id_wr_avail,
  input  logic             id_flush,
  output logic             stall,
  output logic [1:0]       id_fwd_rs,
  output logic [1:0]       id_fwd_rt,
  output logic [1:0]       ex_fwd_rs,
  output logic [1:0]       ex_fwd_rt,
  output logic [1:0]       mem_fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] RD_EX  = 2'b01;
  localparam logic [1:0] RD_MEM = 2'b10;
  localparam logic [1:0] RD_ID  = 2'b11;

  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_dst_q, ex_dst_d;
  logic [2:0]       ex_avail_q, ex_avail_d;
  logic             mem_valid_q, mem_valid_d;
  logic [4:0]       mem_dst_q, mem_dst_d;
  logic [2:0]       mem_avail_q, mem_avail_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_dst_q, wb_dst_d;
  logic [2:0]       wb_avail_q, wb_avail_d;
  logic [1:0]       ex_fwd_rs_q, ex_fwd_rs_d;
  logic [1:0]       ex_fwd_rt_q, ex_fwd_rt_d;
  logic [1:0]       pend_mem_q, pend_mem_d;
  logic [1:0]       mem_fwd_rt_q, mem_fwd_rt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       rs_stall, rt_stall;
  logic [1:0] rs_sel, rt_sel;
  logic [2:0] id_avail;

  function automatic logic [2:0] consumer_stage(input logic [1:0] code);
    case (code)
      RD_ID:   consumer_stage = 3'd1;
      RD_EX:   consumer_stage = 3'd2;
      RD_MEM:  consumer_stage = 3'd3;
      default: consumer_stage = 3'd0;
    endcase
  endfunction

  // Returns {stall, select} for one operand against the youngest matching slot.
  function automatic logic [2:0] resolve(
    input logic [4:0] field,
    input logic [1:0] code,
    input logic       exv,
    input logic [4:0] exd,
    input logic [2:0] exa,
    input logic       memv,
    input logic [4:0] memd,
    input logic [2:0] mema,
    input logic       wbv,
    input logic [4:0] wbd,
    input logic [2:0] wba
  );
    logic [2:0] s_c;
    logic [2:0] s_p;
    logic [2:0] a;
    logic       hit;
    logic [3:0] k;
    s_c = consumer_stage(code);
    s_p = 3'd0;
    a   = 3'd0;
    hit = 1'b0;
    k   = 4'd0;
    resolve = 3'b000;
    if (s_c != 3'd0 && field != 5'd0) begin
      if (exv && exd == field) begin
        hit = 1'b1; s_p = 3'd2; a = exa;
      end else if (memv && memd == field) begin
        hit = 1'b1; s_p = 3'd3; a = mema;
      end else if (wbv && wbd == field) begin
        hit = 1'b1; s_p = 3'd4; a = wba;
      end
    end
    if (hit) begin
      if ({1'b0, s_c} + {1'b0, s_p} < {1'b0, a} + 4'd2) begin
        resolve[2] = 1'b1;
      end else begin
        k = {1'b0, s_c} + {1'b0, s_p} - 4'd1;
        case (k)
          4'd3:    resolve[1:0] = 2'b01;
          4'd4:    resolve[1:0] = 2'b10;
          default: resolve[1:0] = 2'b00;
        endcase
      end
    end
  endfunction

  always_comb begin
    id_avail = (id_wr_avail == 2'b10) ? 3'd3 : 3'd2;
    {rs_stall, rs_sel} = resolve(id_rs, id_read_rs, ex_valid_q, ex_dst_q, ex_avail_q,
                                 mem_valid_q, mem_dst_q, mem_avail_q,
                                 wb_valid_q, wb_dst_q, wb_avail_q);
    {rt_stall, rt_sel} = resolve(id_rt, id_read_rt, ex_valid_q, ex_dst_q, ex_avail_q,
                                 mem_valid_q, mem_dst_q, mem_avail_q,
                                 wb_valid_q, wb_dst_q, wb_avail_q);
    stall     = rs_stall | rt_stall;
    id_fwd_rs = (id_read_rs == RD_ID) ? rs_sel : 2'b00;
    id_fwd_rt = (id_read_rt == RD_ID) ? rt_sel : 2'b00;
  end

  // Downstream stages always advance; only the EX entry is replaced by a bubble.
  always_comb begin
    mem_valid_d  = ex_valid_q;
    mem_dst_d    = ex_dst_q;
    mem_avail_d  = ex_avail_q;
    wb_valid_d   = mem_valid_q;
    wb_dst_d     = mem_dst_q;
    wb_avail_d   = mem_avail_q;
    mem_fwd_rt_d = pend_mem_q;
    ex_valid_d   = 1'b0;
    ex_dst_d     = 5'd0;
    ex_avail_d   = 3'd2;
    ex_fwd_rs_d  = 2'b00;
    ex_fwd_rt_d  = 2'b00;
    pend_mem_d   = 2'b00;
    if (!(stall || id_flush)) begin
      ex_valid_d  = id_wr_en;
      ex_dst_d    = id_wr_dst;
      ex_avail_d  = id_avail;
      ex_fwd_rs_d = (id_read_rs == RD_EX) ? rs_sel : 2'b00;
      ex_fwd_rt_d = (id_read_rt == RD_EX) ? rt_sel : 2'b00;
      pend_mem_d  = (id_read_rt == RD_MEM) ? rt_sel : 2'b00;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_dst_q     <= 5'd0;
      ex_avail_q   <= 3'd2;
      mem_valid_q  <= 1'b0;
      mem_dst_q    <= 5'd0;
      mem_avail_q  <= 3'd2;
      wb_valid_q   <= 1'b0;
      wb_dst_q     <= 5'd0;
      wb_avail_q   <= 3'd2;
      ex_fwd_rs_q  <= 2'b00;
      ex_fwd_rt_q  <= 2'b00;
      pend_mem_q   <= 2'b00;
      mem_fwd_rt_q <= 2'b00;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_dst_q     <= ex_dst_d;
      ex_avail_q   <= ex_avail_d;
      mem_valid_q  <= mem_valid_d;
      mem_dst_q    <= mem_dst_d;
      mem_avail_q  <= mem_avail_d;
      wb_valid_q   <= wb_valid_d;
      wb_dst_q     <= wb_dst_d;
      wb_avail_q   <= wb_avail_d;
      ex_fwd_rs_q  <= ex_fwd_rs_d;
      ex_fwd_rt_q  <= ex_fwd_rt_d;
      pend_mem_q   <= pend_mem_d;
      mem_fwd_rt_q <= mem_fwd_rt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_fwd_rs  = ex_fwd_rs_q;
  assign ex_fwd_rt  = ex_fwd_rt_q;
  assign mem_fwd_rt = mem_fwd_rt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit; a narrow stall counter makes saturation reachable.
module tb_hazard_fwd_unit;

  localparam int CNT_W = 4;
  localparam logic [1:0] NONE = 2'b00, AT_EX = 2'b01, AT_MEM = 2'b10, AT_ID = 2'b11;
  localparam logic [1:0] AV_EX = 2'b01, AV_MEM = 2'b10;

  logic             clk, rst;
  logic [4:0]       id_rs, id_rt, id_wr_dst;
  logic [1:0]       id_read_rs, id_read_rt, id_wr_avail;
  logic             id_wr_en, id_flush;
  logic             stall;
  logic [1:0]       id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt, mem_fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_read_rs(id_read_rs), .id_read_rt(id_read_rt),
    .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst), .id_wr_avail(id_wr_avail), .id_flush(id_flush),
    .stall(stall), .id_fwd_rs(id_fwd_rs), .id_fwd_rt(id_fwd_rt),
    .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt), .mem_fwd_rt(mem_fwd_rt),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rrs,
                        input logic [1:0] rrt, input logic we, input logic [4:0] dst,
                        input logic [1:0] av, input logic fl);
    id_rs = rs; id_rt = rt; id_read_rs = rrs; id_read_rt = rrt;
    id_wr_en = we; id_wr_dst = dst; id_wr_avail = av; id_flush = fl;
    #1;
  endtask

  task automatic idle();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b0, 5'd0, 2'b00, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic bump_cnt();
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b want=0", stall); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d want=0", stall_cnt); end
    checks++; if ({ex_fwd_rs, ex_fwd_rt, mem_fwd_rt} !== 6'b0) begin
      failures++; $display("[TB] FAIL reset_sels got=%b want=000000", {ex_fwd_rs, ex_fwd_rt, mem_fwd_rt});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    drain();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd2, AV_MEM, 1'b0);
    tick();
    set_id(5'd2, 5'd4, AT_EX, AT_EX, 1'b1, 5'd3, AV_EX, 1'b0);
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%b want=1", stall); end
    bump_cnt();
    tick();
    checks++; if (ex_fwd_rs !== 2'b00) begin failures++; $display("[TB] FAIL lu_bubble_sel got=%b want=00", ex_fwd_rs); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL lu_release got=%b want=0", stall); end
    tick();
    idle();
    checks++; if (ex_fwd_rs !== 2'b10) begin failures++; $display("[TB] FAIL lu_ex_fwd_rs got=%b want=10", ex_fwd_rs); end
    checks++; if (ex_fwd_rt !== 2'b00) begin failures++; $display("[TB] FAIL lu_ex_fwd_rt got=%b want=00", ex_fwd_rt); end
    checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("[TB] FAIL lu_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_branch();
    drain();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd5, AV_EX, 1'b0);
    tick();
    set_id(5'd5, 5'd0, AT_ID, AT_ID, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL br_stall got=%b want=1", stall); end
    bump_cnt();
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL br_release got=%b want=0", stall); end
    checks++; if (id_fwd_rs !== 2'b01) begin failures++; $display("[TB] FAIL br_id_fwd_rs got=%b want=01", id_fwd_rs); end
    checks++; if (id_fwd_rt !== 2'b00) begin failures++; $display("[TB] FAIL br_id_fwd_rt got=%b want=00", id_fwd_rt); end
    tick();
    idle();
  endtask

  task automatic test_store_data();
    drain();
    set_id(5'd1, 5'd0, AT_EX, NONE, 1'b1, 5'd6, AV_MEM, 1'b0);
    tick();
    set_id(5'd7, 5'd6, AT_EX, AT_MEM, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL sw_stall got=%b want=0", stall); end
    tick();
    idle();
    checks++; if (mem_fwd_rt !== 2'b00) begin failures++; $display("[TB] FAIL sw_mem_early got=%b want=00", mem_fwd_rt); end
    checks++; if (ex_fwd_rt !== 2'b00) begin failures++; $display("[TB] FAIL sw_ex_fwd_rt got=%b want=00", ex_fwd_rt); end
    tick();
    checks++; if (mem_fwd_rt !== 2'b10) begin failures++; $display("[TB] FAIL sw_mem_fwd got=%b want=10", mem_fwd_rt); end
    tick();
    checks++; if (mem_fwd_rt !== 2'b00) begin failures++; $display("[TB] FAIL sw_mem_after got=%b want=00", mem_fwd_rt); end
  endtask

  task automatic test_youngest();
    drain();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd1, AV_EX, 1'b0);
    tick();
    // odd avail code 11 must behave like an EX-available result
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd1, 2'b11, 1'b0);
    tick();
    set_id(5'd1, 5'd9, AT_EX, AT_EX, 1'b1, 5'd8, AV_EX, 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL yg_stall got=%b want=0", stall); end
    tick();
    set_id(5'd1, 5'd0, AT_ID, NONE, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (ex_fwd_rs !== 2'b01) begin failures++; $display("[TB] FAIL yg_ex_fwd_rs got=%b want=01", ex_fwd_rs); end
    checks++; if (ex_fwd_rt !== 2'b00) begin failures++; $display("[TB] FAIL yg_ex_fwd_rt got=%b want=00", ex_fwd_rt); end
    checks++; if (id_fwd_rs !== 2'b01) begin failures++; $display("[TB] FAIL yg_id_fwd_rs got=%b want=01", id_fwd_rs); end
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL yg_id_stall got=%b want=0", stall); end
    idle();
  endtask

  task automatic test_r0_flush();
    drain();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd0, AV_MEM, 1'b0);
    tick();
    set_id(5'd0, 5'd0, AT_ID, AT_ID, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL r0_stall got=%b want=0", stall); end
    checks++; if (id_fwd_rs !== 2'b00) begin failures++; $display("[TB] FAIL r0_id_fwd got=%b want=00", id_fwd_rs); end
    tick();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd5, AV_EX, 1'b0);
    tick();
    set_id(5'd5, 5'd0, AT_ID, NONE, 1'b1, 5'd9, AV_MEM, 1'b1);
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL fl_stall got=%b want=1", stall); end
    bump_cnt();
    tick();
    set_id(5'd9, 5'd0, AT_EX, NONE, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL fl_bubble got=%b want=0", stall); end
    checks++; if (stall_cnt !== exp_cnt) begin failures++; $display("[TB] FAIL fl_cnt got=%0d want=%0d", stall_cnt, exp_cnt); end
    tick();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd10, AV_MEM, 1'b1);
    tick();
    set_id(5'd10, 5'd0, AT_EX, NONE, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL fl_only got=%b want=0", stall); end
    tick();
    idle();
  endtask

  task automatic test_reset_saturate();
    drain();
    set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd1, AV_EX, 1'b0);
    tick();
    set_id(5'd1, 5'd0, AT_EX, NONE, 1'b1, 5'd2, AV_MEM, 1'b0);
    tick();
    set_id(5'd2, 5'd0, AT_ID, NONE, 1'b0, 5'd0, 2'b00, 1'b0);
    checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL rs_pre_stall got=%b want=1", stall); end
    checks++; if (ex_fwd_rs !== 2'b01) begin failures++; $display("[TB] FAIL rs_pre_ex got=%b want=01", ex_fwd_rs); end
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rs_stall got=%b want=0", stall); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("[TB] FAIL rs_cnt got=%0d want=0", stall_cnt); end
    checks++; if ({ex_fwd_rs, ex_fwd_rt, mem_fwd_rt} !== 6'b0) begin
      failures++; $display("[TB] FAIL rs_sels got=%b want=000000", {ex_fwd_rs, ex_fwd_rt, mem_fwd_rt});
    end
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      set_id(5'd0, 5'd0, NONE, NONE, 1'b1, 5'd2, AV_MEM, 1'b0);
      tick();
      set_id(5'd2, 5'd0, AT_ID, NONE, 1'b0, 5'd0, 2'b00, 1'b0);
      if (stall) bump_cnt();
      tick();
      if (stall) bump_cnt();
      tick();
      tick();
      if (i == 3) begin
        checks++; if (stall_cnt !== 4'd8) begin failures++; $display("[TB] FAIL sat_mid got=%0d want=8", stall_cnt); end
      end
    end
    idle();
    checks++; if (exp_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_stalls got=%0d want=15", exp_cnt); end
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_hold got=%0d want=15", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_store_data();
    test_youngest();
    test_r0_flush();
    test_reset_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
